// File: rtl/isw_share_feeder.sv
// isw_share_feeder: feeder for an order-D ISW masked AND gadget.
// Collects fresh random bits serially into a pool. When the pool is full, it
// accepts one unmasked operand pair (a, b) and presents, for one cycle, D+1
// Boolean shares of each operand plus the D(D+1)/2 gadget randomness bits.
// A 3-stage delay line marks the cycle in which the gadget output is valid.
//
// Ports:
//   clk, reset      : rising-edge clock, synchronous active-high reset
//   in_a, in_b      : unmasked operand bits
//   in_valid        : operand pair offered
//   in_ready        : pool full, operand can be accepted (decode of cnt)
//   rnd_bit         : fresh random bit from the entropy source
//   rnd_valid       : rnd_bit valid this cycle
//   out_a, out_b    : NS shares of a / b (bit i -> gadget port_a_i / port_b_i)
//   out_r           : NR gadget randomness bits (bit j -> gadget port_r_j)
//   out_valid       : shares and randomness valid (1-cycle pulse)
//   done            : gadget port_c valid (out_valid delayed by 3 cycles)
module isw_share_feeder #(
  parameter int unsigned D = 5,
  localparam int unsigned NS = D + 1,
  localparam int unsigned NR = D * (D + 1) / 2,
  localparam int unsigned POOL = 2 * D + NR
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_a,
  input  logic          in_b,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          rnd_bit,
  input  logic          rnd_valid,
  output logic [NS-1:0] out_a,
  output logic [NS-1:0] out_b,
  output logic [NR-1:0] out_r,
  output logic          out_valid,
  output logic          done
);

  localparam int unsigned CW = $clog2(POOL + 1);

  typedef enum logic {
    S_FILL = 1'b0,
    S_FULL = 1'b1
  } state_t;

  logic [POOL-1:0] pool;
  logic [CW-1:0]   cnt;
  logic [1:0]      dly;
  state_t          state;
  logic            xfer;
  logic [D-1:0]    mask_a;
  logic [D-1:0]    mask_b;
  logic            par_a;
  logic            par_b;

  // FILL/FULL is fully determined by the fill counter.
  assign state    = (cnt == CW'(POOL)) ? S_FULL : S_FILL;
  assign in_ready = (state == S_FULL);
  assign xfer     = in_valid && in_ready;

  // First D pool bits mask a, next D mask b, the remainder feed the gadget.
  assign mask_a = pool[D-1:0];
  assign mask_b = pool[2*D-1:D];
  assign par_a  = ^mask_a;
  assign par_b  = ^mask_b;

  // Pool fill, share generation and done delay line.
  always_ff @(posedge clk) begin
    if (reset) begin
      pool      <= '0;
      cnt       <= '0;
      dly       <= '0;
      done      <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
    end else begin
      dly       <= {dly[0], out_valid};
      done      <= dly[1];
      out_valid <= xfer;
      if (xfer) begin
        out_a <= {in_a ^ par_a, mask_a};
        out_b <= {in_b ^ par_b, mask_b};
        out_r <= pool[POOL-1:2*D];
        // Clearing the pool guarantees no bit is reused; a random bit
        // arriving in this cycle is dropped on purpose.
        pool  <= '0;
        cnt   <= '0;
      end else begin
        // Shares are forced to zero so stale randomness never leaks out.
        out_a <= '0;
        out_b <= '0;
        out_r <= '0;
        if (state == S_FILL && rnd_valid) begin
          for (int unsigned i = 0; i < POOL; i++) begin
            if (cnt == CW'(i)) pool[i] <= rnd_bit;
          end
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: doc/isw_share_feeder.md
# isw_share_feeder

Upstream feeder for the order-D ISW masked AND gadget. It collects fresh random bits serially from an external entropy source into a randomness pool. It Boolean-masks one unmasked operand pair (a, b) into D+1 shares each and presents, in a single cycle, the shares plus the D(D+1)/2 fresh gadget randomness bits that the gadget consumes. It also tracks the gadget's fixed 3-cycle latency, so downstream logic knows when the gadget's `port_c` shares are valid.

## Interface
- `D`, default 5: masking order; number of shares is D+1.
- `NS` (derived), D+1 = 6: share count.
- `NR` (derived), D(D+1)/2 = 15: gadget randomness width.
- `POOL` (derived), 2D+NR = 25: random bits consumed per operation.
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `in_a`, in, 1: unmasked operand a.
- `in_b`, in, 1: unmasked operand b.
- `in_valid`, in, 1: operand pair offered.
- `in_ready`, out, 1: pool full, so an operand can be accepted.
- `rnd_bit`, in, 1: fresh random bit from the entropy source.
- `rnd_valid`, in, 1: `rnd_bit` is valid this cycle.
- `out_a`, out, NS: shares of a; bit i drives gadget `port_a_i`.
- `out_b`, out, NS: shares of b; bit i drives gadget `port_b_i`.
- `out_r`, out, NR: gadget randomness; bit j drives `port_r_j`.
- `out_valid`, out, 1: shares and r are valid this cycle (1-cycle pulse).
- `done`, out, 1: 1-cycle pulse marking the cycle in which the gadget's `port_c_*` carries the result.

## Operation
- Internal state:
  - `pool[POOL-1:0]`;
  - fill counter `cnt`, 0..POOL;
  - 3-stage valid delay line.
- States:
  - FILL (`cnt < POOL`);
  - FULL (`cnt == POOL`).
- FILL:
  - when `rnd_valid` is high, write `pool[cnt] <= rnd_bit` and increment `cnt`;
  - the first bit received after empty lands in `pool[0]`;
  - `in_ready = 0`.
- FULL:
  - `in_ready = 1`;
  - `rnd_valid` bits are discarded;
  - the state is held until a transfer occurs.
- A transfer (`in_valid && in_ready`) registers the outputs as follows. Let m = `pool[D-1:0]` and n = `pool[2D-1:D]`.
  - `out_a[D-1:0] = m`; `out_a[D] = in_a ^ XOR(m)`.
  - `out_b[D-1:0] = n`; `out_b[D] = in_b ^ XOR(n)`.
  - `out_r = pool[POOL-1:2D]`.
  - `out_valid <= 1`.
  - `cnt <= 0` and `pool <= 0`; a `rnd_bit` arriving in the transfer cycle is dropped.
- No pool bit is ever used for more than one operation.
- Invariants: XOR(`out_a`) = `in_a` and XOR(`out_b`) = `in_b`.
- Outside the `out_valid` cycle, `out_a`, `out_b` and `out_r` are 0, so stale randomness never reaches the gadget.
- The `done` delay line shifts `out_valid` by exactly 3 cycles, matching the gadget's operand-to-`port_c` latency.

## Timing
- Reset values:
  - `cnt = 0`, `pool = 0`, delay line = 0;
  - `out_a = out_b = out_r = 0`;
  - `out_valid = 0`, `done = 0`, `in_ready = 0`.
- `in_ready` is a combinational decode of `cnt` only. It is high in the cycle after the POOL-th accepted bit.
- Latency:
  - a transfer at edge k gives `out_valid` high in cycle k+1;
  - `done` is high in cycle k+4, which is the cycle the gadget's `port_c` is valid.
- Throughput: at most one operation per POOL+1 cycles, i.e. 26 cycles for D=5 with continuous `rnd_valid`.
- `in_valid` while FILL: stalls with no side effect; the operand must be held until `in_ready`.
- Reset mid-fill or mid-pipeline:
  - the pool is discarded;
  - in-flight `out_valid`/`done` pulses are cancelled (the `done` delay line is cleared);
  - no `done` pulse appears for an operation issued before reset.

## Test plan
- Reset, then 25 cycles with `rnd_valid=1`, `rnd_bit=1` -> `in_ready` is 0 through cycle 25 and 1 from cycle 26; `out_valid` stays 0.
- Pool all 1s, `in_a=1`, `in_b=0`, `in_valid=1` -> next cycle `out_a=6'b011111`, `out_b=6'b111111`, `out_r=15'h7FFF`, `out_valid=1`; the following cycle all outputs are 0.
- `in_valid` held high from reset with `rnd_valid` toggling every other cycle -> first `out_valid` exactly 1 cycle after the 25th valid bit is accepted; exactly one pulse per 25 accepted bits.
- Reset asserted at `cnt=12` -> `cnt` returns to 0 and `in_ready` stays low until 25 new bits have been accepted; no pulse for the earlier bits.
- Back-to-back operations with random operands and a random bit stream, gadget instantiated downstream -> `done` 3 cycles after each `out_valid`; XOR(`port_c_0..5`) = `in_a & in_b` at every `done`; no `pool` bit index reused across operations (scoreboard check).
